// File: rtl/rf_wb_arbiter_if.sv
// Write-back request channels into the register-file arbiter.
// One channel carries the retiring pipeline instruction and the other carries
// long-latency unit results (divider/CSR). Each channel has its own ready.
interface rf_wb_arbiter_if;
  logic        pipe_valid;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic [31:0] pipe_pc;
  logic        pipe_ready;

  logic        lop_valid;
  logic [4:0]  lop_waddr;
  logic [31:0] lop_wdata;
  logic [31:0] lop_pc;
  logic        lop_ready;

  // Producer side: the pipeline and the long-op units
  modport master (
    output pipe_valid, pipe_we, pipe_waddr, pipe_wdata, pipe_pc,
    output lop_valid, lop_waddr, lop_wdata, lop_pc,
    input  pipe_ready, lop_ready
  );

  // Arbiter side
  modport slave (
    input  pipe_valid, pipe_we, pipe_waddr, pipe_wdata, pipe_pc,
    input  lop_valid, lop_waddr, lop_wdata, lop_pc,
    output pipe_ready, lop_ready
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter.
// Shares the single regfile write port between retiring pipeline instructions
// and results from long-latency units. Long-op results wait in a 2-entry FIFO.
// The pipeline normally wins the port. A queued long-op result takes the port
// when the pipeline is idle, or after it has waited STARVE_MAX pipeline writes.
// The winning entry is registered, so the write and the trace outputs appear
// one cycle after the grant.
module rf_wb_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  rf_wb_arbiter_if.slave      bus,
  output logic                lop_pending,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [31:0]         rf_wdata,
  output logic [31:0]         debug_wb_pc,
  output logic [3:0]          debug_wb_rf_wen,
  output logic [4:0]          debug_wb_rf_wnum,
  output logic [31:0]         debug_wb_rf_wdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  // Long-op FIFO storage and control
  logic [4:0]  fifo_waddr [2];
  logic [31:0] fifo_wdata [2];
  logic [31:0] fifo_pc    [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [3:0]  starve_cnt;

  logic fifo_ne;
  logic fifo_full;
  logic starve_hit;
  logic lop_enq;
  logic lop_grant;
  logic pipe_grant;

  // Grant decision and handshakes. A result that arrives into an empty FIFO
  // cannot be granted in the same cycle, because grants only look at the
  // registered count.
  always_comb begin
    fifo_ne    = (count != 2'd0);
    fifo_full  = (count == 2'd2);
    starve_hit = (starve_cnt == STARVE_LIM);
    lop_grant  = ~reset & fifo_ne & (~bus.pipe_valid | starve_hit);
    pipe_grant = ~reset & ~lop_grant & bus.pipe_valid;
    lop_enq    = bus.lop_valid & ~reset & ~fifo_full;
  end

  // A full FIFO refuses new results even when it is draining this cycle.
  assign bus.lop_ready  = ~reset & ~fifo_full;
  assign bus.pipe_ready = ~reset & ~lop_grant;
  assign lop_pending    = fifo_ne;

  // FIFO payload write. The data needs no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (lop_enq) begin
      fifo_waddr[wr_ptr] <= bus.lop_waddr;
      fifo_wdata[wr_ptr] <= bus.lop_wdata;
      fifo_pc[wr_ptr]    <= bus.lop_pc;
    end
  end

  // FIFO pointers and occupancy. Reset drops any queued results.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (lop_enq)
        wr_ptr <= ~wr_ptr;
      if (lop_grant)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, lop_enq} - {1'b0, lop_grant};
    end
  end

  // Starvation counter: counts pipeline writes that go ahead of a queued result.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (lop_grant || !fifo_ne) begin
      starve_cnt <= 4'd0;
    end else if (pipe_grant && !starve_hit) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Register the granted entry. An idle cycle clears the write enable and
  // keeps the address, data and pc from the last write.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we       <= 1'b0;
      rf_waddr    <= 5'd0;
      rf_wdata    <= 32'd0;
      debug_wb_pc <= 32'd0;
    end else if (lop_grant) begin
      rf_we       <= (fifo_waddr[rd_ptr] != 5'd0);
      rf_waddr    <= fifo_waddr[rd_ptr];
      rf_wdata    <= fifo_wdata[rd_ptr];
      debug_wb_pc <= fifo_pc[rd_ptr];
    end else if (pipe_grant) begin
      rf_we       <= bus.pipe_we & (bus.pipe_waddr != 5'd0);
      rf_waddr    <= bus.pipe_waddr;
      rf_wdata    <= bus.pipe_wdata;
      debug_wb_pc <= bus.pipe_pc;
    end else begin
      rf_we       <= 1'b0;
    end
  end

  // The trace outputs mirror the registered write port.
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter using hand-computed expectations.
module tb_rf_wb_arbiter;
  logic        clk;
  logic        reset;
  logic        lop_pending;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int n_chk;
  int n_pass;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter #(.STARVE_MAX(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus.slave),
    .lop_pending       (lop_pending),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Advance past the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic set_pipe(input logic v, input logic we, input logic [4:0] a,
                          input logic [31:0] d, input logic [31:0] pc);
    bus.pipe_valid = v;
    bus.pipe_we    = we;
    bus.pipe_waddr = a;
    bus.pipe_wdata = d;
    bus.pipe_pc    = pc;
  endtask

  task automatic set_lop(input logic v, input logic [4:0] a,
                         input logic [31:0] d, input logic [31:0] pc);
    bus.lop_valid = v;
    bus.lop_waddr = a;
    bus.lop_wdata = d;
    bus.lop_pc    = pc;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b1;
    set_pipe(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    set_lop(1'b0, 5'd0, 32'd0, 32'd0);
    tick();
    // Inputs active during reset must be ignored.
    set_pipe(1'b1, 1'b1, 5'd3, 32'h33, 32'h1c000040);
    set_lop(1'b1, 5'd4, 32'h44, 32'h1c000080);
    settle();
    chk("rst_pipe_ready", 32'(bus.pipe_ready), 32'd0);
    chk("rst_lop_ready", 32'(bus.lop_ready), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_pc", debug_wb_pc, 32'd0);
    chk("rst_wdata", debug_wb_rf_wdata, 32'd0);
    tick();
    chk("rst_pending", 32'(lop_pending), 32'd0);
    chk("rst_we_hold", 32'(rf_we), 32'd0);
    reset = 1'b0;
    set_pipe(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    set_lop(1'b0, 5'd0, 32'd0, 32'd0);
    settle();
    chk("post_rst_pipe_ready", 32'(bus.pipe_ready), 32'd1);
    chk("post_rst_lop_ready", 32'(bus.lop_ready), 32'd1);
    chk("post_rst_pending", 32'(lop_pending), 32'd0);

    // Plain pipeline write
    set_pipe(1'b1, 1'b1, 5'd5, 32'h1234, 32'h1c000000);
    settle();
    chk("p1_pipe_ready", 32'(bus.pipe_ready), 32'd1);
    tick();
    set_pipe(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    settle();
    chk("p1_rf_we", 32'(rf_we), 32'd1);
    chk("p1_waddr", 32'(rf_waddr), 32'd5);
    chk("p1_wdata", rf_wdata, 32'h1234);
    chk("p1_wen", 32'(debug_wb_rf_wen), 32'hf);
    chk("p1_pc", debug_wb_pc, 32'h1c000000);
    chk("p1_wnum", 32'(debug_wb_rf_wnum), 32'd5);
    tick();
    chk("idle_rf_we", 32'(rf_we), 32'd0);
    chk("idle_wen", 32'(debug_wb_rf_wen), 32'd0);
    chk("idle_waddr_hold", 32'(rf_waddr), 32'd5);
    chk("idle_pc_hold", debug_wb_pc, 32'h1c000000);

    // A write to x0 retires but does not write
    set_pipe(1'b1, 1'b1, 5'd0, 32'h55, 32'h1c000004);
    tick();
    set_pipe(1'b1, 1'b0, 5'd3, 32'h66, 32'h1c000008);
    settle();
    chk("x0_rf_we", 32'(rf_we), 32'd0);
    chk("x0_wen", 32'(debug_wb_rf_wen), 32'd0);
    chk("x0_pc", debug_wb_pc, 32'h1c000004);
    chk("x0_wdata", rf_wdata, 32'h55);
    tick();
    // pipe_we=0 still takes a slot and updates the trace pc
    set_pipe(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    settle();
    chk("nowe_rf_we", 32'(rf_we), 32'd0);
    chk("nowe_pc", debug_wb_pc, 32'h1c000008);
    chk("nowe_waddr", 32'(rf_waddr), 32'd3);

    // Single long-op result with an idle pipeline
    set_lop(1'b1, 5'd7, 32'hdead, 32'h1c000100);
    settle();
    chk("l1_lop_ready", 32'(bus.lop_ready), 32'd1);
    chk("l1_no_same_cycle_grant", 32'(bus.pipe_ready), 32'd1);
    tick();
    set_lop(1'b0, 5'd0, 32'd0, 32'd0);
    settle();
    chk("l1_pending", 32'(lop_pending), 32'd1);
    chk("l1_grant_cycle", 32'(bus.pipe_ready), 32'd0);
    chk("l1_rf_we_before", 32'(rf_we), 32'd0);
    tick();
    chk("l1_rf_we", 32'(rf_we), 32'd1);
    chk("l1_waddr", 32'(rf_waddr), 32'd7);
    chk("l1_wdata", rf_wdata, 32'hdead);
    chk("l1_pc", debug_wb_pc, 32'h1c000100);
    chk("l1_pending_after", 32'(lop_pending), 32'd0);

    // Starvation: the queued result waits out four pipeline writes
    set_lop(1'b1, 5'd9, 32'h99, 32'h1c000200);
    set_pipe(1'b1, 1'b1, 5'd1, 32'h100, 32'h1c001000);
    settle();
    chk("sv_pipe_ready_0", 32'(bus.pipe_ready), 32'd1);
    tick();
    set_lop(1'b0, 5'd0, 32'd0, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      set_pipe(1'b1, 1'b1, 5'(i + 1), 32'h100 + 32'(i), 32'h1c001000 + 32'(4 * i));
      settle();
      chk("sv_pipe_ready", 32'(bus.pipe_ready), 32'd1);
      chk("sv_prev_waddr", 32'(rf_waddr), 32'(i));
      tick();
    end
    set_pipe(1'b1, 1'b1, 5'd6, 32'h105, 32'h1c001014);
    settle();
    chk("sv_stall", 32'(bus.pipe_ready), 32'd0);
    chk("sv_last_pipe_waddr", 32'(rf_waddr), 32'd5);
    tick();
    settle();
    chk("sv_resume", 32'(bus.pipe_ready), 32'd1);
    chk("sv_lop_waddr", 32'(rf_waddr), 32'd9);
    chk("sv_lop_wdata", rf_wdata, 32'h99);
    chk("sv_lop_pc", debug_wb_pc, 32'h1c000200);
    chk("sv_pending", 32'(lop_pending), 32'd0);
    tick();
    set_pipe(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    settle();
    chk("sv_held_waddr", 32'(rf_waddr), 32'd6);
    chk("sv_held_wdata", rf_wdata, 32'h105);
    tick();

    // Full FIFO backpressure and ordering
    set_pipe(1'b1, 1'b1, 5'd10, 32'h200, 32'h1c002000);
    set_lop(1'b1, 5'd11, 32'ha1, 32'h1c003000);
    tick();
    set_lop(1'b1, 5'd12, 32'hb2, 32'h1c003004);
    settle();
    chk("ff_ready_one", 32'(bus.lop_ready), 32'd1);
    tick();
    set_lop(1'b1, 5'd13, 32'hc3, 32'h1c003008);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("ff_full_refuse", 32'(bus.lop_ready), 32'd0);
      tick();
    end
    settle();
    chk("ff_refuse_on_deq", 32'(bus.lop_ready), 32'd0);
    chk("ff_lop_grant", 32'(bus.pipe_ready), 32'd0);
    tick();
    settle();
    chk("ff_ready_after_deq", 32'(bus.lop_ready), 32'd1);
    chk("ff_first_waddr", 32'(rf_waddr), 32'd11);
    chk("ff_first_wdata", rf_wdata, 32'ha1);
    tick();
    set_lop(1'b0, 5'd0, 32'd0, 32'd0);
    set_pipe(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    settle();
    chk("ff_pipe_between", 32'(rf_waddr), 32'd10);
    tick();
    chk("ff_second_waddr", 32'(rf_waddr), 32'd12);
    chk("ff_second_pc", debug_wb_pc, 32'h1c003004);
    tick();
    chk("ff_third_waddr", 32'(rf_waddr), 32'd13);
    chk("ff_third_wdata", rf_wdata, 32'hc3);
    chk("ff_drained", 32'(lop_pending), 32'd0);
    tick();

    // Reset with a full FIFO drops everything queued
    set_pipe(1'b1, 1'b1, 5'd14, 32'h300, 32'h1c004000);
    set_lop(1'b1, 5'd20, 32'he0, 32'h1c005000);
    tick();
    set_lop(1'b1, 5'd21, 32'he1, 32'h1c005004);
    tick();
    set_lop(1'b0, 5'd0, 32'd0, 32'd0);
    settle();
    chk("mr_pending_full", 32'(lop_pending), 32'd1);
    chk("mr_full", 32'(bus.lop_ready), 32'd0);
    reset = 1'b1;
    set_pipe(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    settle();
    chk("mr_pipe_ready", 32'(bus.pipe_ready), 32'd0);
    tick();
    chk("mr_rf_we", 32'(rf_we), 32'd0);
    chk("mr_pending", 32'(lop_pending), 32'd0);
    chk("mr_pc_zero", debug_wb_pc, 32'd0);
    reset = 1'b0;
    settle();
    chk("mr_post_pipe_ready", 32'(bus.pipe_ready), 32'd1);
    chk("mr_post_lop_ready", 32'(bus.lop_ready), 32'd1);
    chk("mr_post_pending", 32'(lop_pending), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_no_stale_we", 32'(rf_we), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
